sink_pipe_master: RTL and testbench

//  Sink-side request engine for the AHB2AHB bridge. Pops request packets from the sink request FIFO and drives a pipelined AHB-lite master.
//  The next address phase overlaps the current data phase. Supports HSIZE carried in each packet, two-cycle ERROR retry, response-credit gating and a sleep drain handshake.

---
 rtl/sink_pipe_master.sv | 210 +++++++++++++++++++++
 tb/tb_sink_pipe_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sink_pipe_master.sv
// sink_pipe_master: sink-side request engine of the AHB2AHB bridge.
// Pops request packets from the sink request FIFO, drives a pipelined
// AHB-lite master (address phase overlaps the previous data phase), handles
// the two-cycle ERROR response, gates issue on response-FIFO credit and
// supports a drain-then-sleep handshake. Responses {err, rdata} are pushed
// into the sink response FIFO one cycle after each data phase completes.
module sink_pipe_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int P_SIZE     = 3,
  parameter bit WR_RSP     = 1'b1
) (
  input  logic                              i_clk_sink,
  input  logic                              i_rstn_sink,
  input  logic                              i_sink_sleep_req,
  output logic                              o_sink_sleep_ack,
  input  logic                              i_req_empty,
  input  logic [ADDR_WIDTH+DATA_WIDTH+3:0]  i_req_pkt,
  output logic                              o_req_rd_en,
  input  logic [P_SIZE-1:0]                 i_rsp_free,
  output logic                              o_rsp_wr_en,
  output logic [DATA_WIDTH:0]               o_rsp_pkt,
  input  logic                              i_hready,
  input  logic                              i_hresp,
  input  logic [DATA_WIDTH-1:0]             i_hrdata,
  output logic [1:0]                        o_htrans,
  output logic                              o_hwrite,
  output logic [2:0]                        o_hsize,
  output logic [ADDR_WIDTH-1:0]             o_haddr,
  output logic [DATA_WIDTH-1:0]             o_hwdata,
  output logic [7:0]                        o_err_cnt
);

  localparam int PKT_W = ADDR_WIDTH + DATA_WIDTH + 4;
  // Common width for the credit comparison so narrow P_SIZE still works.
  localparam int CW = (P_SIZE > 2) ? P_SIZE : 2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Bus state: normal pipelined operation, or the second cycle of an
  // ERROR response during which the address phase must be withdrawn.
  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } bus_state_t;

  bus_state_t r_state;

  // Address stage
  logic                  r_a_v;
  logic                  r_a_wr;
  logic [2:0]            r_a_size;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic [DATA_WIDTH-1:0] r_a_wdata;

  // Data stage
  logic                  r_d_v;
  logic                  r_d_wr;
  logic [DATA_WIDTH-1:0] r_d_wdata;

  // Response and status registers
  logic                  r_rsp_wr_en;
  logic [DATA_WIDTH:0]   r_rsp_pkt;
  logic [7:0]            r_err_cnt;
  logic                  r_sleep_ack;

  // Packet field extraction: {rd0_wr1, hsize[2:0], addr, wdata}
  logic                  w_pkt_wr;
  logic [2:0]            w_pkt_size;
  logic [ADDR_WIDTH-1:0] w_pkt_addr;
  logic [DATA_WIDTH-1:0] w_pkt_wdata;

  assign w_pkt_wr    = i_req_pkt[PKT_W-1];
  assign w_pkt_size  = i_req_pkt[PKT_W-2 -: 3];
  assign w_pkt_addr  = i_req_pkt[DATA_WIDTH +: ADDR_WIDTH];
  assign w_pkt_wdata = i_req_pkt[DATA_WIDTH-1:0];

  // Control terms
  logic          w_err_c;
  logic          w_gen_a;
  logic          w_gen_d;
  logic [1:0]    w_inflight;
  logic [CW-1:0] w_free_ext;
  logic [CW-1:0] w_inflight_ext;
  logic          w_credit_ok;
  logic          w_adv;
  logic          w_issue;
  logic          w_complete;
  logic          w_err_start;
  logic          w_idle;

  assign w_err_c = (r_state == ST_ERR);

  // A stage entry will produce a response once it completes.
  assign w_gen_a = r_a_v && (!r_a_wr || WR_RSP);
  assign w_gen_d = r_d_v && (!r_d_wr || WR_RSP);

  assign w_inflight     = {1'b0, w_gen_a} + {1'b0, w_gen_d};
  assign w_free_ext     = CW'(i_rsp_free);
  assign w_inflight_ext = CW'(w_inflight);
  // Pre-edge in-flight count is used even if a slot frees this edge:
  // conservative, never overcommits the response FIFO.
  assign w_credit_ok    = (w_free_ext > w_inflight_ext);

  // Pipeline advances on a ready bus cycle outside the ERROR window.
  assign w_adv = i_hready && !w_err_c;

  assign w_issue = !i_req_empty && !i_sink_sleep_req && !w_err_c &&
                   (!r_a_v || i_hready) && w_credit_ok;

  assign w_complete  = r_d_v && i_hready;
  assign w_err_start = r_d_v && i_hresp && !i_hready && !w_err_c;
  assign w_idle      = !r_a_v && !r_d_v && !w_err_c;

  // Outputs
  assign o_req_rd_en      = w_issue;
  assign o_htrans         = (r_a_v && !w_err_c) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign o_hwrite         = r_a_wr;
  assign o_hsize          = r_a_size;
  assign o_haddr          = r_a_addr;
  assign o_hwdata         = r_d_wdata;
  assign o_rsp_wr_en      = r_rsp_wr_en;
  assign o_rsp_pkt        = r_rsp_pkt;
  assign o_err_cnt        = r_err_cnt;
  assign o_sink_sleep_ack = r_sleep_ack;

  // Address stage: load on pop, retire when the bus accepts it; held
  // through wait states and the ERROR window so it can be re-presented.
  always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
    if (!i_rstn_sink) begin
      r_a_v     <= 1'b0;
      r_a_wr    <= 1'b0;
      r_a_size  <= 3'd0;
      r_a_addr  <= '0;
      r_a_wdata <= '0;
    end else if (w_issue) begin
      r_a_v     <= 1'b1;
      r_a_wr    <= w_pkt_wr;
      r_a_size  <= w_pkt_size;
      r_a_addr  <= w_pkt_addr;
      r_a_wdata <= w_pkt_wdata;
    end else if (w_adv) begin
      r_a_v     <= 1'b0;
    end
  end

  // Data stage: takes the address stage on a ready cycle; an ERROR
  // completion empties it without pulling the held address phase forward.
  always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
    if (!i_rstn_sink) begin
      r_d_v     <= 1'b0;
      r_d_wr    <= 1'b0;
      r_d_wdata <= '0;
    end else if (w_adv) begin
      r_d_v     <= r_a_v;
      r_d_wr    <= r_a_wr;
      r_d_wdata <= r_a_wdata;
    end else if (w_err_c && i_hready) begin
      r_d_v     <= 1'b0;
    end
  end

  // Bus state: enter ERROR on the first (not-ready) ERROR cycle, leave on
  // the second (ready) one.
  always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
    if (!i_rstn_sink) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (w_err_start) r_state <= ST_ERR;
        ST_ERR:  if (i_hready)    r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Response push: one cycle after a completing data phase that reports.
  always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
    if (!i_rstn_sink) begin
      r_rsp_wr_en <= 1'b0;
      r_rsp_pkt   <= '0;
    end else begin
      r_rsp_wr_en <= w_complete && w_gen_d;
      if (w_complete && w_gen_d) begin
        r_rsp_pkt <= {i_hresp, (r_d_wr ? {DATA_WIDTH{1'b0}} : i_hrdata)};
      end
    end
  end

  // Error counter: every ERROR completion, reported or not, saturating.
  always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
    if (!i_rstn_sink) begin
      r_err_cnt <= 8'd0;
    end else if (w_complete && i_hresp && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Sleep acknowledge: set once drained while requested, held while the
  // request stays high, dropped the edge after the request falls.
  always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
    if (!i_rstn_sink) begin
      r_sleep_ack <= 1'b0;
    end else begin
      r_sleep_ack <= i_sink_sleep_req && (r_sleep_ack || w_idle);
    end
  end

endmodule

// File: tb/tb_sink_pipe_master.sv
// Directed bench for sink_pipe_master: request FIFO modelled as a queue,
// slave handshake driven per cycle, expected values hand-derived.
module tb_sink_pipe_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = AW + DW + 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sleep_req;
  logic          sleep_ack;
  logic          req_empty;
  logic [PW-1:0] req_pkt;
  logic          req_rd_en;
  logic [2:0]    rsp_free;
  logic          rsp_wr_en;
  logic [DW:0]   rsp_pkt;
  logic          hready;
  logic          hresp;
  logic [DW-1:0] hrdata;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  sink_pipe_master dut (
    .i_clk_sink       (clk),
    .i_rstn_sink      (rst_n),
    .i_sink_sleep_req (sleep_req),
    .o_sink_sleep_ack (sleep_ack),
    .i_req_empty      (req_empty),
    .i_req_pkt        (req_pkt),
    .o_req_rd_en      (req_rd_en),
    .i_rsp_free       (rsp_free),
    .o_rsp_wr_en      (rsp_wr_en),
    .o_rsp_pkt        (rsp_pkt),
    .i_hready         (hready),
    .i_hresp          (hresp),
    .i_hrdata         (hrdata),
    .o_htrans         (htrans),
    .o_hwrite         (hwrite),
    .o_hsize          (hsize),
    .o_haddr          (haddr),
    .o_hwdata         (hwdata),
    .o_err_cnt        (err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [PW-1:0] req_q [$];

  // Values sampled at the falling edge of the most recent cycle
  logic [1:0]    s_htrans;
  logic          s_hwrite;
  logic [2:0]    s_hsize;
  logic [AW-1:0] s_haddr;
  logic [DW-1:0] s_hwdata;
  logic          s_rd_en;
  logic          s_rsp_wr_en;
  logic [DW:0]   s_rsp_pkt;
  logic          s_ack;
  logic [7:0]    s_err_cnt;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic wr, input logic [2:0] sz,
                                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {wr, sz, a, d};
  endfunction

  task automatic drive_req();
    req_empty = (req_q.size() == 0);
    req_pkt   = (req_q.size() == 0) ? '0 : req_q[0];
  endtask

  task automatic push_req(input logic [PW-1:0] p);
    req_q.push_back(p);
    drive_req();
  endtask

  // One bus cycle: sample mid-cycle, cross the rising edge, apply the pop.
  task automatic tick();
    @(negedge clk);
    s_htrans    = htrans;
    s_hwrite    = hwrite;
    s_hsize     = hsize;
    s_haddr     = haddr;
    s_hwdata    = hwdata;
    s_rd_en     = req_rd_en;
    s_rsp_wr_en = rsp_wr_en;
    s_rsp_pkt   = rsp_pkt;
    s_ack       = sleep_ack;
    s_err_cnt   = err_cnt;
    if (s_rsp_wr_en) $display("rsp cyc=%0d pkt=%h", cyc, s_rsp_pkt);
    if (s_rd_en)     $display("pop cyc=%0d", cyc);
    @(posedge clk);
    #1;
    if (s_rd_en && req_q.size() > 0) req_q.delete(0);
    drive_req();
    cyc++;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sleep_req = 1'b0; rsp_free = 3'd4;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    drive_req();
    idle_ticks(2);
    check_val("rst_htrans", s_htrans, 0);
    check_val("rst_ack", s_ack, 0);
    check_val("rst_errcnt", s_err_cnt, 0);
    check_val("rst_rsp", s_rsp_wr_en, 0);
    check_val("rst_hwdata", s_hwdata, 0);
    rst_n = 1'b1;
    idle_ticks(1);

    // Single write: NONSEQ at pop+1, hwdata at pop+2, response at pop+3
    push_req(mk_pkt(1'b1, 3'b010, 32'h100, 32'hCAFE));
    tick();
    check_val("t1_pop", s_rd_en, 1);
    check_val("t1_idle0", s_htrans, 0);
    tick();
    check_val("t1_nonseq", s_htrans, 2);
    check_val("t1_haddr", s_haddr, 32'h100);
    check_val("t1_hwrite", s_hwrite, 1);
    check_val("t1_hsize", s_hsize, 2);
    check_val("t1_nopop", s_rd_en, 0);
    tick();
    check_val("t1_hwdata", s_hwdata, 32'hCAFE);
    check_val("t1_idle2", s_htrans, 0);
    tick();
    check_val("t1_rsp_en", s_rsp_wr_en, 1);
    check_val("t1_rsp_pkt", s_rsp_pkt, 0);
    idle_ticks(2);

    // Four back-to-back reads, zero wait, hrdata = 0xA0 + cycle index
    for (int i = 0; i < 4; i++) push_req(mk_pkt(1'b0, 3'b010, 32'h200 + 32'(4*i), '0));
    for (int c = 0; c < 8; c++) begin
      hrdata = 32'hA0 + 32'(c);
      tick();
      check_val($sformatf("t2_pop_c%0d", c), s_rd_en, (c <= 3) ? 1 : 0);
      check_val($sformatf("t2_htrans_c%0d", c), s_htrans, (c >= 1 && c <= 4) ? 2 : 0);
      if (c >= 1 && c <= 4) check_val($sformatf("t2_haddr_c%0d", c), s_haddr, 32'h200 + 32'(4*(c-1)));
      check_val($sformatf("t2_rspen_c%0d", c), s_rsp_wr_en, (c >= 3 && c <= 6) ? 1 : 0);
      if (c >= 3 && c <= 6) check_val($sformatf("t2_rsp_c%0d", c), s_rsp_pkt, 32'hA0 + 32'(c-1));
    end
    idle_ticks(1);

    // Read gets a two-cycle ERROR, following write is re-presented
    push_req(mk_pkt(1'b0, 3'b010, 32'h300, '0));
    push_req(mk_pkt(1'b1, 3'b010, 32'h304, 32'hBEEF));
    tick();                                   // c0: pop read
    check_val("t3_pop0", s_rd_en, 1);
    tick();                                   // c1: NONSEQ read, pop write
    check_val("t3_pop1", s_rd_en, 1);
    check_val("t3_haddr1", s_haddr, 32'h300);
    hready = 1'b0; hresp = 1'b1;
    tick();                                   // c2: ERROR cycle 1
    check_val("t3_htrans_e1", s_htrans, 2);
    check_val("t3_haddr_e1", s_haddr, 32'h304);
    hready = 1'b1; hresp = 1'b1; hrdata = 32'h5555;
    tick();                                   // c3: ERROR cycle 2
    check_val("t3_htrans_e2", s_htrans, 0);
    check_val("t3_nopop_e2", s_rd_en, 0);
    hresp = 1'b0; hrdata = '0;
    tick();                                   // c4: write re-issued
    check_val("t3_reissue", s_htrans, 2);
    check_val("t3_readdr", s_haddr, 32'h304);
    check_val("t3_rewrite", s_hwrite, 1);
    check_val("t3_rsp_en", s_rsp_wr_en, 1);
    check_val("t3_rsp_err", s_rsp_pkt, 33'h1_0000_5555);
    check_val("t3_errcnt", s_err_cnt, 1);
    tick();                                   // c5: write data phase
    check_val("t3_hwdata", s_hwdata, 32'hBEEF);
    check_val("t3_idle5", s_htrans, 0);
    tick();                                   // c6: write response
    check_val("t3_wrsp_en", s_rsp_wr_en, 1);
    check_val("t3_wrsp", s_rsp_pkt, 0);
    idle_ticks(2);

    // Single response credit: one read in flight, pops every 3 cycles
    rsp_free = 3'd1;
    for (int i = 0; i < 3; i++) push_req(mk_pkt(1'b0, 3'b010, 32'h400 + 32'(4*i), '0));
    for (int c = 0; c < 11; c++) begin
      hrdata = 32'hB0 + 32'(c);
      tick();
      check_val($sformatf("t4_pop_c%0d", c), s_rd_en, (c == 0 || c == 3 || c == 6) ? 1 : 0);
      check_val($sformatf("t4_rspen_c%0d", c), s_rsp_wr_en, (c == 3 || c == 6 || c == 9) ? 1 : 0);
      if (c == 3 || c == 6 || c == 9) check_val($sformatf("t4_rsp_c%0d", c), s_rsp_pkt, 32'hB0 + 32'(c-1));
    end
    rsp_free = 3'd4;
    idle_ticks(1);

    // Sleep after the second pop: drain, ack, release, resume
    for (int i = 0; i < 4; i++) push_req(mk_pkt(1'b0, 3'b010, 32'h500 + 32'(4*i), '0));
    for (int c = 0; c < 12; c++) begin
      sleep_req = (c >= 2 && c <= 6);
      hrdata = 32'hC0 + 32'(c);
      tick();
      check_val($sformatf("t5_pop_c%0d", c), s_rd_en, (c == 0 || c == 1 || c == 7 || c == 8) ? 1 : 0);
      check_val($sformatf("t5_ack_c%0d", c), s_ack, (c >= 5 && c <= 7) ? 1 : 0);
      if (c == 8) check_val("t5_haddr8", s_haddr, 32'h508);
      if (c == 9) check_val("t5_haddr9", s_haddr, 32'h50C);
      check_val($sformatf("t5_rspen_c%0d", c), s_rsp_wr_en, (c == 3 || c == 4 || c == 10 || c == 11) ? 1 : 0);
    end
    sleep_req = 1'b0;
    idle_ticks(1);

    // Reset during a wait-stated write data phase
    push_req(mk_pkt(1'b1, 3'b010, 32'h600, 32'h1234));
    tick();                                   // c0: pop
    tick();                                   // c1: NONSEQ
    hready = 1'b0;                            // c2: wait state on data phase
    #1;
    check_val("t6_hwdata_pre", hwdata, 32'h1234);
    check_val("t6_haddr_pre", haddr, 32'h600);
    rst_n = 1'b0;
    #1;
    check_val("t6_hwdata_rst", hwdata, 0);
    check_val("t6_haddr_rst", haddr, 0);
    check_val("t6_htrans_rst", htrans, 0);
    check_val("t6_errcnt_rst", err_cnt, 0);
    tick();
    check_val("t6_norsp0", s_rsp_wr_en, 0);
    hready = 1'b1;
    tick();
    check_val("t6_norsp1", s_rsp_wr_en, 0);
    rst_n = 1'b1;
    idle_ticks(1);

    // No credit with nothing in flight: no pop, bus idle
    rsp_free = 3'd0;
    push_req(mk_pkt(1'b0, 3'b000, 32'h700, '0));
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val($sformatf("t7_nopop_c%0d", c), s_rd_en, 0);
      check_val($sformatf("t7_idle_c%0d", c), s_htrans, 0);
    end
    rsp_free = 3'd4;
    tick();
    check_val("t7_pop", s_rd_en, 1);
    tick();
    check_val("t7_nonseq", s_htrans, 2);
    check_val("t7_haddr", s_haddr, 32'h700);
    check_val("t7_hsize", s_hsize, 0);
    hrdata = 32'h77;
    tick();
    hrdata = '0;
    tick();
    check_val("t7_rsp_en", s_rsp_wr_en, 1);
    check_val("t7_rsp", s_rsp_pkt, 32'h77);
    idle_ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
